// File: rtl/disp_pkg.sv
// Shared seven-segment definitions: segment bit positions, hex glyph table
// and the nibble decoder used by display_scan_mux.
package disp_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyphs as {g,f,e,d,c,b,a}, active-high; polarity is applied at the pins.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/digit scan counters: slot_cnt runs 0..SCAN_DIV-1, idx advances on each
// slot wrap and runs 0..NUM_DIGITS-1.
module scan_timer #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  localparam int SW = $clog2(SCAN_DIV),
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [SW-1:0] slot_cnt_o,
  output logic [IW-1:0] idx_o,
  output logic          slot_end_o,
  output logic          frame_end_o
);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    slot_end_o  = (slot_cnt_q == SW'(SCAN_DIV - 1));
    frame_end_o = slot_end_o && (idx_q == IW'(NUM_DIGITS - 1));
    slot_cnt_d  = slot_end_o ? '0 : slot_cnt_q + 1'b1;
    idx_d       = idx_q;
    if (slot_end_o) begin
      idx_d = frame_end_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
    end
  end

  assign slot_cnt_o = slot_cnt_q;
  assign idx_o      = idx_q;

endmodule

// File: rtl/display_scan_mux.sv
// Multiplexed seven-segment driver with guard interval and frame-coherent
// input shadows. Optional `DISP_BRIGHT_EN adds a 4-bit BRIGHT on-time control.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    CLK_100MHZ,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   DIG_EN,
`ifdef DISP_BRIGHT_EN
  input  logic [3:0]              BRIGHT,
`endif
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              SEG,
  output logic                    DP_OUT,
  output logic                    FRAME
);

  localparam int  SW  = $clog2(SCAN_DIV);
  localparam int  IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit  INV = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = INV ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = INV ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = INV;

  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic          slot_end, frame_end;

  scan_timer #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)) u_timer (
    .clk_i       (CLK_100MHZ),
    .rst_i       (RST),
    .slot_cnt_o  (slot_cnt),
    .idx_o       (idx),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  logic                    init_q;
  logic [4*NUM_DIGITS-1:0] sh_digits_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_en_q;
  logic                    frame_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    capture;
  logic                    lit;
  logic [4*NUM_DIGITS-1:0] nib_shift;
  logic                    unused_slot_end;

  assign unused_slot_end = slot_end;

`ifdef DISP_BRIGHT_EN
  logic [3:0] bright_q;
  int         thr [16];

  // On-time thresholds per BRIGHT code; 64-bit product avoids overflow.
  for (genvar b = 0; b < 16; b++) begin : g_thr
    assign thr[b] = int'((longint'(SCAN_DIV - GUARD) * longint'(b + 1)) >>> 4);
  end
`endif

  // The reset flag forces one capture on the first edge after release.
  assign capture = init_q | frame_end;

  always_comb begin
    nib_shift = sh_digits_q >> {idx, 2'b00};
    lit       = (int'(slot_cnt) >= GUARD) && sh_en_q[idx];
`ifdef DISP_BRIGHT_EN
    lit       = lit && ((int'(slot_cnt) - GUARD) < thr[bright_q]);
`endif
    an_d  = lit ? (NUM_DIGITS'(1) << idx) : '0;
    seg_d = lit ? seg_decode(nib_shift[3:0]) : 7'h00;
    dp_d  = lit & sh_dp_q[idx];
    if (INV) begin
      an_d  = ~an_d;
      seg_d = ~seg_d;
      dp_d  = ~dp_d;
    end
  end

  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      init_q      <= 1'b1;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_en_q     <= '0;
`ifdef DISP_BRIGHT_EN
      bright_q    <= '0;
`endif
      frame_q     <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
    end else begin
      init_q  <= 1'b0;
      frame_q <= capture;
      if (capture) begin
        sh_digits_q <= DIGITS;
        sh_dp_q     <= DP;
        sh_en_q     <= DIG_EN;
`ifdef DISP_BRIGHT_EN
        bright_q    <= BRIGHT;
`endif
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign AN     = an_q;
  assign SEG    = seg_q;
  assign DP_OUT = dp_q;
  assign FRAME  = frame_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: 4-digit and 3-digit instances,
// SCAN_DIV=8, GUARD=2, active-low outputs.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp, dig_en;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out, frame;
  logic [2:0]  an3;
  logic [6:0]  seg3;
  logic        dp3, frame3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  display_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2), .ACTIVE_LOW(1)) dut (
    .CLK_100MHZ (clk),
    .RST        (rst),
    .DIGITS     (digits),
    .DP         (dp),
    .DIG_EN     (dig_en),
`ifdef DISP_BRIGHT_EN
    .BRIGHT     (bright),
`endif
    .AN         (an),
    .SEG        (seg),
    .DP_OUT     (dp_out),
    .FRAME      (frame)
  );

  display_scan_mux #(.NUM_DIGITS(3), .SCAN_DIV(8), .GUARD(2), .ACTIVE_LOW(1)) dut3 (
    .CLK_100MHZ (clk),
    .RST        (rst),
    .DIGITS     (digits[11:0]),
    .DP         (dp[2:0]),
    .DIG_EN     (dig_en[2:0]),
`ifdef DISP_BRIGHT_EN
    .BRIGHT     (bright),
`endif
    .AN         (an3),
    .SEG        (seg3),
    .DP_OUT     (dp3),
    .FRAME      (frame3)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frame();
    int b = 0;
    do begin
      step();
      b++;
    end while (frame !== 1'b1 && b < 100);
    n_tests++;
    if (frame !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_frame: FRAME=%b after %0d cycles, required 1", frame, b);
    end
  endtask

  task automatic wait_frame3();
    int b = 0;
    do begin
      step();
      b++;
    end while (frame3 !== 1'b1 && b < 100);
    n_tests++;
    if (frame3 !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_frame3: FRAME=%b after %0d cycles, required 1", frame3, b);
    end
  endtask

  task automatic test_reset();
    logic [15:0] vec [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'hA5C3};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      digits = vec[i];
      dp     = vec[i][3:0];
      dig_en = vec[i][7:4];
      step();
      n_tests += 4;
      if (an !== 4'hF)     begin n_fail++; $display("FAIL reset_an: got %h required F", an); end
      if (seg !== 7'h7F)   begin n_fail++; $display("FAIL reset_seg: got %h required 7F", seg); end
      if (dp_out !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b required 1", dp_out); end
      if (frame !== 1'b0)  begin n_fail++; $display("FAIL reset_frame: got %b required 0", frame); end
    end
  endtask

  task automatic test_scan_decode();
    logic [6:0] dec [4] = '{7'h40, 7'h0E, 7'h30, 7'h08};
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int c, idx, slot;
    digits = 16'hA3F0;
    dp     = 4'h0;
    dig_en = 4'hF;
    rst    = 1'b0;
    step();
    n_tests += 2;
    if (frame !== 1'b1) begin n_fail++; $display("FAIL release_frame: got %b required 1", frame); end
    if (an !== 4'hF)    begin n_fail++; $display("FAIL release_an: got %h required F", an); end
    for (int k = 2; k <= 33; k++) begin
      step();
      c = k - 1; idx = (c / 8) % 4; slot = c % 8;
      exp_an  = (slot < 2) ? 4'hF : ~(4'b0001 << idx);
      exp_seg = (slot < 2) ? 7'h7F : dec[idx];
      n_tests += 4;
      if (an !== exp_an)   begin n_fail++; $display("FAIL scan_an k=%0d: got %h required %h", k, an, exp_an); end
      if (seg !== exp_seg) begin n_fail++; $display("FAIL decode_seg k=%0d: got %h required %h", k, seg, exp_seg); end
      if (dp_out !== 1'b1) begin n_fail++; $display("FAIL scan_dp k=%0d: got %b required 1", k, dp_out); end
      if (frame !== (k == 32)) begin n_fail++; $display("FAIL scan_frame k=%0d: got %b required %b", k, frame, k == 32); end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] nv;
    for (int n = 0; n < 16; n++) begin
      nv = 4'(n);
      digits = {12'h000, nv};
      wait_frame();
      repeat (3) step();
      n_tests += 2;
      if (seg !== ~seg_tab[n]) begin n_fail++; $display("FAIL sweep_seg %h: got %h required %h", nv, seg, ~seg_tab[n]); end
      if (an !== 4'hE)         begin n_fail++; $display("FAIL sweep_an %h: got %h required E", nv, an); end
    end
  endtask

  task automatic test_tearing();
    digits = 16'h1111;
    wait_frame();
    repeat (3) step();
    repeat (16) step();
    n_tests += 2;
    if (an !== 4'hB)    begin n_fail++; $display("FAIL tear_an2: got %h required B", an); end
    if (seg !== 7'h79)  begin n_fail++; $display("FAIL tear_seg2_pre: got %h required 79", seg); end
    digits = 16'h2222;
    step();
    n_tests++;
    if (seg !== 7'h79)  begin n_fail++; $display("FAIL tear_seg2_post: got %h required 79", seg); end
    repeat (7) step();
    n_tests += 2;
    if (an !== 4'h7)    begin n_fail++; $display("FAIL tear_an3: got %h required 7", an); end
    if (seg !== 7'h79)  begin n_fail++; $display("FAIL tear_seg3: got %h required 79", seg); end
    wait_frame();
    repeat (3) step();
    n_tests += 2;
    if (an !== 4'hE)    begin n_fail++; $display("FAIL tear_new_an: got %h required E", an); end
    if (seg !== 7'h24)  begin n_fail++; $display("FAIL tear_new_seg0: got %h required 24", seg); end
    repeat (8) step();
    n_tests++;
    if (seg !== 7'h24)  begin n_fail++; $display("FAIL tear_new_seg1: got %h required 24", seg); end
  endtask

  task automatic test_enable_dp();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp, lit;
    int c, idx, slot;
    digits = 16'h8888;
    dig_en = 4'b0101;
    dp     = 4'b0100;
    wait_frame();
    for (int j = 1; j <= 32; j++) begin
      step();
      c = j - 1; idx = c / 8; slot = c % 8;
      lit     = (slot >= 2) && (idx == 0 || idx == 2);
      exp_an  = lit ? ~(4'b0001 << idx) : 4'hF;
      exp_seg = lit ? 7'h00 : 7'h7F;
      exp_dp  = (lit && idx == 2) ? 1'b0 : 1'b1;
      n_tests += 4;
      if (an !== exp_an)     begin n_fail++; $display("FAIL en_an j=%0d: got %h required %h", j, an, exp_an); end
      if (seg !== exp_seg)   begin n_fail++; $display("FAIL en_seg j=%0d: got %h required %h", j, seg, exp_seg); end
      if (dp_out !== exp_dp) begin n_fail++; $display("FAIL en_dp j=%0d: got %b required %b", j, dp_out, exp_dp); end
      if (frame !== (j == 32)) begin n_fail++; $display("FAIL en_frame j=%0d: got %b required %b", j, frame, j == 32); end
    end
  endtask

  task automatic test_nonpow2();
    logic [2:0] exp_an;
    int c, idx, slot;
    dig_en = 4'hF;
    dp     = 4'h0;
    wait_frame3();
    wait_frame3();
    for (int j = 1; j <= 48; j++) begin
      step();
      c = j - 1; idx = (c / 8) % 3; slot = c % 8;
      exp_an = (slot < 2) ? 3'b111 : ~(3'b001 << idx);
      n_tests += 3;
      if (an3 !== exp_an) begin n_fail++; $display("FAIL np2_an j=%0d: got %b required %b", j, an3, exp_an); end
      if ($countones(~an3) > 1) begin n_fail++; $display("FAIL np2_onehot j=%0d: got %b required at most one low", j, an3); end
      if (frame3 !== (j == 24 || j == 48)) begin
        n_fail++; $display("FAIL np2_frame j=%0d: got %b required %b", j, frame3, (j == 24 || j == 48));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int b = 0;
    while (an === 4'hF && b < 40) begin
      step();
      b++;
    end
    n_tests++;
    if (an === 4'hF) begin n_fail++; $display("FAIL midrst_lit: AN=%h, required a lit digit", an); end
    #2 rst = 1'b1;
    #1;
    n_tests += 4;
    if (an !== 4'hF)     begin n_fail++; $display("FAIL midrst_an: got %h required F", an); end
    if (seg !== 7'h7F)   begin n_fail++; $display("FAIL midrst_seg: got %h required 7F", seg); end
    if (dp_out !== 1'b1) begin n_fail++; $display("FAIL midrst_dp: got %b required 1", dp_out); end
    if (frame !== 1'b0)  begin n_fail++; $display("FAIL midrst_frame: got %b required 0", frame); end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_tests++;
    if (frame !== 1'b1) begin n_fail++; $display("FAIL midrst_release_frame: got %b required 1", frame); end
    repeat (2) step();
    n_tests += 2;
    if (an !== 4'hE)   begin n_fail++; $display("FAIL midrst_restart_an: got %h required E", an); end
    if (seg !== 7'h00) begin n_fail++; $display("FAIL midrst_restart_seg: got %h required 00", seg); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    digits = '0;
    dp     = '0;
    dig_en = '0;
    bright = 4'hF;
    @(negedge clk);
    test_reset();
    test_scan_decode();
    test_sweep();
    test_tearing();
    test_enable_dp();
    test_nonpow2();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
